// File: rtl/decode_queued_pkg.sv
// Shared types and encodings for the queued decode stage and its decoder.
package decode_queued_pkg;

    localparam logic [6:0] OP_IMM        = 7'b0010011;
    localparam logic [6:0] OP            = 7'b0110011;
    localparam logic [6:0] LOAD          = 7'b0000011;
    localparam logic [6:0] STORE         = 7'b0100011;
    localparam logic [6:0] BRANCH        = 7'b1100011;
    localparam logic [6:0] LUI           = 7'b0110111;
    localparam logic [6:0] AUIPC         = 7'b0010111;
    localparam logic [6:0] JAL           = 7'b1101111;
    localparam logic [6:0] JALR          = 7'b1100111;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic       stall;
        logic       flush;
    } PipeControl;

    typedef struct packed {
        logic       stall_req;
        logic [3:0] flush_req;
    } PipeRequest;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } FetchInfo;

    // Register indices are zero whenever the matching *_valid flag is low.
    typedef struct packed {
        logic        enable;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic        rd_valid;
        logic [4:0]  rs1;
        logic        rs1_valid;
        logic [4:0]  rs2;
        logic        rs2_valid;
        logic [31:0] imm;
    } DecodeInfo;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } LoadHist;

endpackage

// File: rtl/decode_queued_comb.sv
// Pure combinational RV32I (+ optional M) decoder: FetchInfo -> DecodeInfo.
module decode_comb
    import decode_queued_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  FetchInfo  fetch_info,
    output DecodeInfo info,
    output logic      muldiv,
    output logic      illegal
);

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst   = fetch_info.inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    logic        legal, rs1v, rs2v, rdv, md;
    logic [31:0] imm;

    // Classify the opcode, check funct fields and pick the immediate format.
    always_comb begin
        legal = 1'b0;
        rs1v  = 1'b0;
        rs2v  = 1'b0;
        rdv   = 1'b0;
        md    = 1'b0;
        imm   = '0;
        case (opcode)
            OP_IMM: begin
                if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                       legal = 1'b1;
                imm = imm_i; rs1v = 1'b1; rdv = 1'b1;
            end
            OP: begin
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                end else if (funct7 == 7'b0100000) begin
                    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                end else if (ENABLE_M && funct7 == FUNCT7_MULDIV) begin
                    legal = 1'b1;
                    md    = 1'b1;
                end
                rs1v = 1'b1; rs2v = 1'b1; rdv = 1'b1;
            end
            LOAD: begin
                legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
                imm = imm_i; rs1v = 1'b1; rdv = 1'b1;
            end
            STORE: begin
                legal = !funct3[2] && (funct3[1:0] != 2'b11);
                imm = imm_s; rs1v = 1'b1; rs2v = 1'b1;
            end
            BRANCH: begin
                legal = (funct3[2:1] != 2'b01);
                imm = imm_b; rs1v = 1'b1; rs2v = 1'b1;
            end
            LUI, AUIPC: begin
                legal = 1'b1; imm = imm_u; rdv = 1'b1;
            end
            JAL: begin
                legal = 1'b1; imm = imm_j; rdv = 1'b1;
            end
            JALR: begin
                legal = (funct3 == 3'b000);
                imm = imm_i; rs1v = 1'b1; rdv = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Assemble the output record; an illegal encoding yields an all-zero record.
    always_comb begin
        info   = '0;
        muldiv = 1'b0;
        if (legal) begin
            info.enable    = 1'b1;
            info.pc        = fetch_info.pc;
            info.opcode    = opcode;
            info.funct3    = funct3;
            info.funct7    = funct7;
            info.rd        = rdv  ? inst[11:7]  : 5'd0;
            info.rd_valid  = rdv;
            info.rs1       = rs1v ? inst[19:15] : 5'd0;
            info.rs1_valid = rs1v;
            info.rs2       = rs2v ? inst[24:20] : 5'd0;
            info.rs2_valid = rs2v;
            info.imm       = imm;
            muldiv         = md;
        end
        illegal = !legal;
    end

endmodule

// File: rtl/decode_queued.sv
// Decode stage with a DEPTH-entry instruction queue and load-use hazard detection.
module decode_queued
    import decode_queued_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LOAD_STAGES = 1,
    parameter bit          ENABLE_M    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  PipeControl                   pipe,
    output PipeRequest                   req,
    input  logic                         fetch_valid,
    output logic                         fetch_ready,
    input  FetchInfo                     fetch_info,
    output DecodeInfo                    info,
    output DecodeInfo                    info_ff,
    output logic                         muldiv_ff,
    output logic                         error_ff,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    FetchInfo              mem_q [DEPTH];
    FetchInfo              mem_d [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    DecodeInfo             info_ff_q, info_ff_d;
    logic                  muldiv_q, muldiv_d;
    logic                  error_q, error_d;
    LoadHist               hist_q [LOAD_STAGES];
    LoadHist               hist_d [LOAD_STAGES];

    DecodeInfo             head_info;
    logic                  head_muldiv, head_illegal, head_valid;
    logic                  push, pop, hazard, issue_load;

    decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (
        .fetch_info (mem_q[rd_ptr_q]),
        .info       (head_info),
        .muldiv     (head_muldiv),
        .illegal    (head_illegal)
    );

    assign head_valid  = (count_q != '0);
    assign info        = head_valid ? head_info : '0;
    assign fetch_ready = (count_q != FULL) && !pipe.flush && !error_q;
    assign push        = fetch_valid && fetch_ready;

    // Load-use hazard: a valid source register of the head matches a pending load rd.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned k = 0; k < LOAD_STAGES; k++) begin
            if (hist_q[k].valid) begin
                if (info.rs1_valid && info.rs1 != 5'd0 && info.rs1 == hist_q[k].rd) hazard = 1'b1;
                if (info.rs2_valid && info.rs2 != 5'd0 && info.rs2 == hist_q[k].rd) hazard = 1'b1;
            end
        end
    end

    // Next-state: queue push, then stall > flush > error > hazard > issue for the rest.
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        info_ff_d  = info_ff_q;
        muldiv_d   = muldiv_q;
        error_d    = error_q;
        hist_d     = hist_q;
        pop        = 1'b0;
        issue_load = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = fetch_info;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (pipe.stall) begin
            // hold issue state and history; pushes above still land
        end else if (pipe.flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            info_ff_d = '0;
            muldiv_d  = 1'b0;
            error_d   = 1'b0;
            for (int unsigned k = 0; k < LOAD_STAGES; k++) hist_d[k] = '0;
        end else begin
            info_ff_d = '0;
            muldiv_d  = 1'b0;
            if (error_q || (head_valid && head_illegal)) begin
                error_d = 1'b1;
            end else if (!hazard && head_valid) begin
                info_ff_d  = info;
                muldiv_d   = head_muldiv;
                pop        = 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                issue_load = (head_info.opcode == LOAD) && (head_info.rd != 5'd0);
            end
            for (int unsigned k = 1; k < LOAD_STAGES; k++) hist_d[k] = hist_q[k-1];
            hist_d[0].valid = issue_load;
            hist_d[0].rd    = issue_load ? head_info.rd : 5'd0;
        end

        if (!pipe.stall && pipe.flush) begin
            count_d = '0;
        end else begin
            count_d = count_q;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            info_ff_q <= '0;
            muldiv_q  <= 1'b0;
            error_q   <= 1'b0;
            for (int unsigned k = 0; k < LOAD_STAGES; k++) hist_q[k] <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            info_ff_q <= info_ff_d;
            muldiv_q  <= muldiv_d;
            error_q   <= error_d;
            hist_q    <= hist_d;
        end
    end

    // Queue storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign req.stall_req = hazard;
    assign req.flush_req = 4'b0000;
    assign info_ff       = info_ff_q;
    assign muldiv_ff     = muldiv_q;
    assign error_ff      = error_q;
    assign count         = count_q;

endmodule

// File: tb/tb_decode_queued.sv
// Directed, table-driven bench for decode_queued.
module tb_decode_queued;
    import decode_queued_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    PipeControl pipe, m_pipe;
    PipeRequest req, m_req;
    logic       fv, m_fv, fready, m_fready;
    FetchInfo   fi, m_fi;
    DecodeInfo  info, info_ff, m_info, m_info_ff;
    logic       muldiv_ff, error_ff, m_muldiv_ff, m_error_ff;
    logic [2:0] count, m_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_queued #(.DEPTH(4), .LOAD_STAGES(2), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .pipe(pipe), .req(req),
        .fetch_valid(fv), .fetch_ready(fready), .fetch_info(fi),
        .info(info), .info_ff(info_ff), .muldiv_ff(muldiv_ff),
        .error_ff(error_ff), .count(count)
    );

    decode_queued #(.DEPTH(4), .LOAD_STAGES(1), .ENABLE_M(1'b0)) dut_m0 (
        .clk(clk), .rst(rst), .pipe(m_pipe), .req(m_req),
        .fetch_valid(m_fv), .fetch_ready(m_fready), .fetch_info(m_fi),
        .info(m_info), .info_ff(m_info_ff), .muldiv_ff(m_muldiv_ff),
        .error_ff(m_error_ff), .count(m_count)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic        rdv, rs1v, rs2v, md, ill;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    localparam logic [31:0] I_ADDI1 = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_ADDI2 = 32'h00700113;  // addi x2,x0,7
    localparam logic [31:0] I_LW5   = 32'h0000A283;  // lw x5,0(x1)
    localparam logic [31:0] I_LW0   = 32'h0000A003;  // lw x0,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h00528333;  // add x6,x5,x5
    localparam logic [31:0] I_ADD60 = 32'h00000333;  // add x6,x0,x0
    localparam logic [31:0] I_MUL   = 32'h02A302B3;  // mul x5,x6,x10

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pipe = '0; fv = 1'b0; fi = '0;
        m_pipe = '0; m_fv = 1'b0; m_fi = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input DecodeInfo d);
        return {13'b0, d.enable, d.rd, d.rs1, d.rs2, d.rd_valid, d.rs1_valid, d.rs2_valid, d.imm};
    endfunction

    function automatic logic [63:0] pk_exp(input vec_t v);
        return {13'b0, !v.ill, v.rd, v.rs1, v.rs2, v.rdv, v.rs1v, v.rs2v, v.imm};
    endfunction

    task automatic set_fi(input logic [31:0] pc, input logic [31:0] inst);
        fi.pc   = pc;
        fi.inst = inst;
    endtask

    initial begin
        //          inst          imm           rd     rs1    rs2    rdv   rs1v  rs2v  md    ill
        vecs[0]  = '{I_ADDI1,      32'h00000005, 5'd1,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFF00113, 32'hFFFFFFFF, 5'd2,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{I_LW5,        32'h00000000, 5'd5,  5'd1,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'hFE21AE23, 32'hFFFFFFFC, 5'd0,  5'd3,  5'd2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd0,  5'd1,  5'd2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h123453B7, 32'h12345000, 5'd7,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFFF197, 32'hFFFFF000, 5'd3,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h801FF0EF, 32'hFFFFF800, 5'd1,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h00008067, 32'h00000000, 5'd0,  5'd1,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{I_ADD6,       32'h00000000, 5'd6,  5'd5,  5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h402081B3, 32'h00000000, 5'd3,  5'd1,  5'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{I_MUL,        32'h00000000, 5'd5,  5'd6,  5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{32'h40325213, 32'h00000403, 5'd4,  5'd4,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'h00000000, 32'h00000000, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{32'h04000033, 32'h00000000, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        do_reset();
        chk("rst_count",   count, 0);
        chk("rst_info_ff", pk(info_ff), 0);
        chk("rst_muldiv",  muldiv_ff, 0);
        chk("rst_error",   error_ff, 0);
        chk("rst_ready",   fready, 1);
        chk("rst_info",    pk(info), 0);
        chk("rst_stall",   req.stall_req, 0);
        chk("rst_flushrq", req.flush_req, 0);
        chk("rst_m0_cnt",  m_count, 0);

        // Decode table: push into an empty queue, check head decode, then issue/error
        for (int i = 0; i < NV; i++) begin
            do_reset();
            set_fi(32'h100, vecs[i].inst);
            fv = 1'b1;
            step();
            fv = 1'b0;
            chk($sformatf("tab%0d_info", i), pk(info), pk_exp(vecs[i]));
            if (!vecs[i].ill) chk($sformatf("tab%0d_pc", i), info.pc, 32'h100);
            step();
            if (vecs[i].ill) begin
                chk($sformatf("tab%0d_err", i),   error_ff, 1);
                chk($sformatf("tab%0d_bub", i),   info_ff.enable, 0);
                chk($sformatf("tab%0d_nopop", i), count, 1);
                chk($sformatf("tab%0d_rdy", i),   fready, 0);
            end else begin
                chk($sformatf("tab%0d_ff", i),  pk(info_ff), pk_exp(vecs[i]));
                chk($sformatf("tab%0d_md", i),  muldiv_ff, vecs[i].md);
                chk($sformatf("tab%0d_cnt", i), count, 0);
                chk($sformatf("tab%0d_err", i), error_ff, 0);
            end
        end

        // A: back-to-back issue, count stays at 1
        do_reset();
        set_fi(32'h0, I_ADDI1); fv = 1'b1; step();
        chk("A_cnt1", count, 1);
        set_fi(32'h4, I_ADDI2); step();
        fv = 1'b0;
        chk("A_pc0", info_ff.pc, 32'h0);
        chk("A_rd1", info_ff.rd, 1);
        chk("A_cnt2", count, 1);
        step();
        chk("A_pc4", info_ff.pc, 32'h4);
        chk("A_rd2", info_ff.rd, 2);
        chk("A_cnt3", count, 0);

        // B: load-use with two history stages -> two bubbles
        do_reset();
        set_fi(32'h0, I_LW5); fv = 1'b1; step();
        set_fi(32'h4, I_ADD6); step();
        fv = 1'b0;
        chk("B_lw_iss", info_ff.rd, 5);
        chk("B_stall0", req.stall_req, 1);
        step();
        chk("B_bub1",   info_ff.enable, 0);
        chk("B_stall1", req.stall_req, 1);
        step();
        chk("B_bub2",   info_ff.enable, 0);
        chk("B_stall2", req.stall_req, 0);
        step();
        chk("B_add_en", info_ff.enable, 1);
        chk("B_add_pc", info_ff.pc, 32'h4);
        // B2: load to x0 never stalls
        do_reset();
        set_fi(32'h0, I_LW0); fv = 1'b1; step();
        set_fi(32'h4, I_ADD60); step();
        fv = 1'b0;
        chk("B2_nostall", req.stall_req, 0);
        step();
        chk("B2_pc", info_ff.pc, 32'h4);
        chk("B2_en", info_ff.enable, 1);

        // C: stall fills the queue, release drains in order, then wrap
        do_reset();
        set_fi(32'h200, I_ADDI1); fv = 1'b1; step();
        set_fi(32'h204, I_ADDI1); step();
        chk("C_iss0", info_ff.pc, 32'h200);
        pipe.stall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_fi(32'h208 + 32'(4 * k), I_ADDI1);
            step();
            chk($sformatf("C_fill%0d", k), count, (k < 3) ? 3'(k + 2) : 3'd4);
        end
        chk("C_full_rdy", fready, 0);
        chk("C_hold", info_ff.pc, 32'h200);
        pipe.stall = 1'b0; fv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("C_drain%0d", k), info_ff.pc, 32'h204 + 32'(4 * k));
        end
        chk("C_empty", count, 0);
        fv = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_fi(32'h300 + 32'(4 * k), I_ADDI1);
            if (k == 4) fv = 1'b0;
            step();
            if (k > 0) chk($sformatf("C_wrap%0d", k), info_ff.pc, 32'h300 + 32'(4 * (k - 1)));
        end

        // D: flush with count=3 and concurrent push
        do_reset();
        set_fi(32'h0, I_LW5); fv = 1'b1; step();
        set_fi(32'h4, I_ADDI1); step();
        pipe.stall = 1'b1;
        set_fi(32'h8, I_ADDI1); step();
        set_fi(32'hC, I_ADDI1); step();
        chk("D_cnt3", count, 3);
        pipe.stall = 1'b0; pipe.flush = 1'b1;
        set_fi(32'h10, I_ADDI1); step();
        pipe.flush = 1'b0; fv = 1'b0;
        chk("D_cnt0", count, 0);
        chk("D_ff0", pk(info_ff), 0);
        chk("D_md0", muldiv_ff, 0);
        set_fi(32'h20, I_ADD6); fv = 1'b1; step();
        fv = 1'b0;
        chk("D_nostall", req.stall_req, 0);
        chk("D_head", info.pc, 32'h20);
        step();
        chk("D_iss", info_ff.pc, 32'h20);

        // E: stall and flush together -> stall wins
        do_reset();
        set_fi(32'h0, I_LW5); fv = 1'b1; step();
        set_fi(32'h4, I_ADD6); step();
        fv = 1'b0;
        chk("E_stall_pre", req.stall_req, 1);
        pipe.stall = 1'b1; pipe.flush = 1'b1; step();
        chk("E_cnt",   count, 1);
        chk("E_ff_pc", info_ff.pc, 32'h0);
        chk("E_ff_rd", info_ff.rd, 5);
        chk("E_hist",  req.stall_req, 1);
        pipe.stall = 1'b0; step();
        pipe.flush = 1'b0;
        chk("E_cnt0",  count, 0);
        chk("E_ff0",   info_ff.enable, 0);
        chk("E_nohaz", req.stall_req, 0);

        // F: mul with ENABLE_M=0 is illegal, sticky until flush
        do_reset();
        m_fi.pc = 32'h40; m_fi.inst = I_MUL; m_fv = 1'b1; step();
        m_fv = 1'b0;
        chk("F_cnt1", m_count, 1);
        chk("F_noerr", m_error_ff, 0);
        step();
        chk("F_err",   m_error_ff, 1);
        chk("F_bub",   m_info_ff.enable, 0);
        chk("F_md",    m_muldiv_ff, 0);
        chk("F_rdy",   m_fready, 0);
        m_fi.inst = I_ADDI1; m_fv = 1'b1; step();
        m_fv = 1'b0;
        chk("F_nopush", m_count, 1);
        chk("F_sticky", m_error_ff, 1);
        m_pipe.flush = 1'b1; step();
        m_pipe.flush = 1'b0; #1;
        chk("F_clr",   m_error_ff, 0);
        chk("F_cnt0",  m_count, 0);
        chk("F_rdy1",  m_fready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queued.md
Name: decode_queued

Overview:
- Parametrised successor to the single-entry decode stage.
- A DEPTH-entry instruction queue decouples fetch from decode; fetch enters it through a valid/ready handshake.
- Load-use hazard detection covers a configurable number of load-result stages; optional M-extension decode.
- Sits between fetch and execute. Drives DecodeInfo into the execute stage and stall requests to the pipeline controller.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- LOAD_STAGES, 1, number of issue cycles after a load during which its rd is unavailable; at least 1.
- ENABLE_M, 1, 1 = decode MUL/DIV (opcode 0110011, funct7 0000001); 0 = treat them as illegal.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pipe  in  PipeControl  pipeline controller stall/flush.
- req  out  PipeRequest  flush_req is tied to 4'b0000; stall_req is the load-use hazard.
- fetch_valid  in  1  fetch_info is valid.
- fetch_ready  out  1  queue can accept.
- fetch_info  in  FetchInfo  pc and inst.
- info  out  DecodeInfo  combinational decode of the queue head; all zeros when the queue is empty.
- info_ff  out  DecodeInfo  registered issue to execute.
- muldiv_ff  out  1  registered; the issued instruction is M-extension.
- error_ff  out  1  sticky illegal-instruction flag.
- count  out  $clog2(DEPTH+1)  queue occupancy.

Behaviour:
- Reset (one clk edge with rst=1): queue empty, count=0, info_ff=0, muldiv_ff=0, error_ff=0, load history cleared.
- Push: fetch_valid && fetch_ready. fetch_ready = (count<DEPTH) && !pipe.flush && !error_ff. Push is combinational-ready; no same-cycle push-through when full.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately.
- Simultaneous push and pop leave count unchanged.
- Decode of the head:
  - Same DecodeInfo field layout and opcode set as the existing decoder: OP-IMM, OP, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
  - Immediates use the I/S/B/U/J sign-extension rules. JALR uses imm_i.
  - MUL/DIV (ENABLE_M=1) decodes as OP with muldiv=1.
  - Any other encoding is illegal.
- Load history: LOAD_STAGES entries of {valid, rd}. Entry k holds the instruction issued k+1 cycles ago.
  - In every cycle with pipe.stall=0, the history shifts.
  - Entry 0 receives valid = (issued instruction is a load && rd != 0).
  - Bubbles insert valid=0.
- hazard = head valid && ((rs1_valid && rs1 != 0 && rs1 matches any valid history rd) || same for rs2). req.stall_req = hazard.
- Register update priority per clk edge: rst > pipe.stall > pipe.flush > error_ff > hazard > issue.
  - pipe.stall: info_ff, muldiv_ff, history and queue head are held. Pushes still occur.
  - pipe.flush:
    - Queue emptied.
    - info_ff=0, muldiv_ff=0.
    - History cleared.
    - error_ff cleared.
    - Any push in the same cycle is blocked.
  - error_ff set (or head illegal):
    - info_ff=0; the head is not popped.
    - error_ff=1, held until flush or reset.
  - hazard: info_ff=0 (bubble); the head is not popped.
  - issue, when the head is valid: info_ff=info, muldiv_ff=decoded muldiv, pop.
  - issue, when the queue is empty: info_ff=0.
- Latency: an instruction pushed at edge N is at the head from cycle N+1. It reaches info_ff at edge N+1 at the earliest when the queue was empty.
- Throughput: one instruction per cycle with no hazards.

Decomposition:
- Additions to the shared common package:
  - Opcode localparams (OP_IMM, OP, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR).
  - FUNCT7_MULDIV.
  - A LoadHist struct {valid, rd}.
- One sub-module, decode_comb: pure combinational FetchInfo -> {DecodeInfo, muldiv, illegal}, parametrised by ENABLE_M. It is reusable by the old decoder.
- Queue storage, pointers and the hazard/history logic stay in decode_queued.

Test Plan:
- Back-to-back push of addi x1,x0,5 / addi x2,x0,7 with queue empty and no stall -> info_ff shows pc 0x0 then 0x4 on consecutive edges, rd=1 then 2; count never exceeds 1.
- LOAD_STAGES=2: lw x5,0(x1), then add x6,x5,x5 -> two bubble cycles (info_ff.enable=0, stall_req=1), then the add issues. Repeat with rd=x0 -> no stall.
- Hold fetch_valid=1 while pipe.stall=1 for 6 cycles (DEPTH=4) -> count reaches 4, fetch_ready=0, info_ff is held. Release -> 4 issues in order; pointer wrap is verified by a further 4 pushes.
- pipe.flush with count=3 and a concurrent fetch_valid -> next cycle count=0, info_ff=0, the pushed instruction is dropped, history is cleared (a following dependent add does not stall).
- pipe.stall and pipe.flush asserted together -> stall wins: queue, info_ff and history are unchanged. Flush alone on the next cycle then empties the queue.
- inst 0x02A302B3 (mul x5,x6,x10): ENABLE_M=1 -> issued with muldiv_ff=1. ENABLE_M=0 -> error_ff=1 sticky, fetch_ready=0, no pop until flush.
